// File: rtl/issue_queue_if.sv
// rtl/issue_queue_if.sv - enqueue, wakeup and issue signal bundle for issue_queue
interface issue_queue_if #(
  parameter int PHY_BITS  = 6,
  parameter int TAG_BITS  = 4,
  parameter int PAYLOAD_W = 48
);
  // Enqueue side (from rename)
  logic                 in_valid;
  logic                 in_ready;
  logic [PHY_BITS-1:0]  in_rs_phy;
  logic                 in_rs_ready;
  logic [PHY_BITS-1:0]  in_rt_phy;
  logic                 in_rt_ready;
  logic [PHY_BITS-1:0]  in_rw_phy;
  logic [TAG_BITS-1:0]  in_rob_tag;
  logic [PAYLOAD_W-1:0] in_payload;

  // Writeback wakeup broadcast
  logic                 wb_valid;
  logic [PHY_BITS-1:0]  wb_phy;

  // Issue side (to execute)
  logic                 out_valid;
  logic                 out_ready;
  logic [PHY_BITS-1:0]  out_rs_phy;
  logic [PHY_BITS-1:0]  out_rt_phy;
  logic [PHY_BITS-1:0]  out_rw_phy;
  logic [TAG_BITS-1:0]  out_rob_tag;
  logic [PAYLOAD_W-1:0] out_payload;

  modport slave (
    input  in_valid, in_rs_phy, in_rs_ready, in_rt_phy, in_rt_ready,
           in_rw_phy, in_rob_tag, in_payload,
           wb_valid, wb_phy, out_ready,
    output in_ready, out_valid, out_rs_phy, out_rt_phy, out_rw_phy,
           out_rob_tag, out_payload
  );

  modport master (
    output in_valid, in_rs_phy, in_rs_ready, in_rt_phy, in_rt_ready,
           in_rw_phy, in_rob_tag, in_payload,
           wb_valid, wb_phy, out_ready,
    input  in_ready, out_valid, out_rs_phy, out_rt_phy, out_rw_phy,
           out_rob_tag, out_payload
  );
endinterface

// File: rtl/issue_queue.sv
// rtl/issue_queue.sv - collapsing out-of-order issue queue; ISSUE_QUEUE_STATS_EN adds full/issue counters
module issue_queue #(
  parameter int DEPTH     = 8,
  parameter int PHY_BITS  = 6,
  parameter int TAG_BITS  = 4,
  parameter int PAYLOAD_W = 48
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  issue_queue_if.slave             q,
  output logic [$clog2(DEPTH):0]   count
`ifdef ISSUE_QUEUE_STATS_EN
  ,
  output logic [31:0]              stat_full_cycles,
  output logic [31:0]              stat_issued
`endif
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  // Per-slot state; slot 0 holds the oldest entry, valid slots are contiguous
  logic                 valid_q  [DEPTH];
  logic                 valid_d  [DEPTH];
  logic                 rs_rdy_q [DEPTH];
  logic                 rs_rdy_d [DEPTH];
  logic                 rt_rdy_q [DEPTH];
  logic                 rt_rdy_d [DEPTH];
  logic [PHY_BITS-1:0]  rs_phy_q [DEPTH];
  logic [PHY_BITS-1:0]  rs_phy_d [DEPTH];
  logic [PHY_BITS-1:0]  rt_phy_q [DEPTH];
  logic [PHY_BITS-1:0]  rt_phy_d [DEPTH];
  logic [PHY_BITS-1:0]  rw_phy_q [DEPTH];
  logic [PHY_BITS-1:0]  rw_phy_d [DEPTH];
  logic [TAG_BITS-1:0]  tag_q    [DEPTH];
  logic [TAG_BITS-1:0]  tag_d    [DEPTH];
  logic [PAYLOAD_W-1:0] pay_q    [DEPTH];
  logic [PAYLOAD_W-1:0] pay_d    [DEPTH];
  logic [CW-1:0]        count_q;
  logic [CW-1:0]        count_d;

  // Wakeup-adjusted ready bits of the currently held entries
  logic                 rs_woken [DEPTH];
  logic                 rt_woken [DEPTH];

  logic                 sel_found;
  logic [IW-1:0]        sel_idx;
  logic                 in_ready_int;
  logic                 issue;
  logic                 enq;
  logic [CW-1:0]        enq_pos;
  logic                 enq_rs_rdy;
  logic                 enq_rt_rdy;

  // Accept only when a slot is free in registered state; no pass-through when full
  assign in_ready_int = (count_q < CW'(DEPTH));
  assign q.in_ready   = in_ready_int;
  assign count        = count_q;

  // Oldest-first select: scan from the top so the lowest ready slot wins
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (valid_q[i] && rs_rdy_q[i] && rt_rdy_q[i]) begin
        sel_found = 1'b1;
        sel_idx   = IW'(i);
      end
    end
  end

  assign q.out_valid   = sel_found;
  assign q.out_rs_phy  = sel_found ? rs_phy_q[sel_idx] : '0;
  assign q.out_rt_phy  = sel_found ? rt_phy_q[sel_idx] : '0;
  assign q.out_rw_phy  = sel_found ? rw_phy_q[sel_idx] : '0;
  assign q.out_rob_tag = sel_found ? tag_q[sel_idx]    : '0;
  assign q.out_payload = sel_found ? pay_q[sel_idx]    : '0;

  assign issue   = sel_found & q.out_ready;
  assign enq     = q.in_valid & in_ready_int;
  // A simultaneous issue frees a slot below, so the new entry lands one lower
  assign enq_pos = count_q - CW'(issue);

  // Incoming sources: already ready, woken this very cycle, or the hardwired zero register
  assign enq_rs_rdy = q.in_rs_ready | (q.wb_valid & (q.wb_phy == q.in_rs_phy)) |
                      (q.in_rs_phy == '0);
  assign enq_rt_rdy = q.in_rt_ready | (q.wb_valid & (q.wb_phy == q.in_rt_phy)) |
                      (q.in_rt_phy == '0);

  // Apply the writeback broadcast to every held entry before any shifting
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      rs_woken[i] = rs_rdy_q[i] | (q.wb_valid & (q.wb_phy == rs_phy_q[i]));
      rt_woken[i] = rt_rdy_q[i] | (q.wb_valid & (q.wb_phy == rt_phy_q[i]));
    end
  end

  // Next state: hold, collapse above the issued slot, append new entry, then flush override
  always_comb begin
    count_d = count_q + CW'(enq) - CW'(issue);

    for (int i = 0; i < DEPTH; i++) begin
      rs_rdy_d[i] = rs_woken[i];
      rt_rdy_d[i] = rt_woken[i];
      rs_phy_d[i] = rs_phy_q[i];
      rt_phy_d[i] = rt_phy_q[i];
      rw_phy_d[i] = rw_phy_q[i];
      tag_d[i]    = tag_q[i];
      pay_d[i]    = pay_q[i];
    end

    for (int i = 0; i < DEPTH - 1; i++) begin
      if (issue && (IW'(i) >= sel_idx)) begin
        rs_rdy_d[i] = rs_woken[i+1];
        rt_rdy_d[i] = rt_woken[i+1];
        rs_phy_d[i] = rs_phy_q[i+1];
        rt_phy_d[i] = rt_phy_q[i+1];
        rw_phy_d[i] = rw_phy_q[i+1];
        tag_d[i]    = tag_q[i+1];
        pay_d[i]    = pay_q[i+1];
      end
    end

    for (int i = 0; i < DEPTH; i++) begin
      if (enq && (CW'(i) == enq_pos)) begin
        rs_rdy_d[i] = enq_rs_rdy;
        rt_rdy_d[i] = enq_rt_rdy;
        rs_phy_d[i] = q.in_rs_phy;
        rt_phy_d[i] = q.in_rt_phy;
        rw_phy_d[i] = q.in_rw_phy;
        tag_d[i]    = q.in_rob_tag;
        pay_d[i]    = q.in_payload;
      end
    end

    if (flush) begin
      count_d = '0;
    end

    // Occupancy is contiguous from slot 0, so valid follows directly from the new count
    for (int i = 0; i < DEPTH; i++) begin
      valid_d[i] = (CW'(i) < count_d);
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i]  <= 1'b0;
        rs_rdy_q[i] <= 1'b0;
        rt_rdy_q[i] <= 1'b0;
        rs_phy_q[i] <= '0;
        rt_phy_q[i] <= '0;
        rw_phy_q[i] <= '0;
        tag_q[i]    <= '0;
        pay_q[i]    <= '0;
      end
    end else begin
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i]  <= valid_d[i];
        rs_rdy_q[i] <= rs_rdy_d[i];
        rt_rdy_q[i] <= rt_rdy_d[i];
        rs_phy_q[i] <= rs_phy_d[i];
        rt_phy_q[i] <= rt_phy_d[i];
        rw_phy_q[i] <= rw_phy_d[i];
        tag_q[i]    <= tag_d[i];
        pay_q[i]    <= pay_d[i];
      end
    end
  end

`ifdef ISSUE_QUEUE_STATS_EN
  logic [31:0] stat_full_cycles_q;
  logic [31:0] stat_full_cycles_d;
  logic [31:0] stat_issued_q;
  logic [31:0] stat_issued_d;

  // Saturating counters; flush leaves them alone and a flushed issue is not counted
  always_comb begin
    stat_full_cycles_d = stat_full_cycles_q;
    stat_issued_d      = stat_issued_q;
    if (!in_ready_int && q.in_valid && (stat_full_cycles_q != '1)) begin
      stat_full_cycles_d = stat_full_cycles_q + 32'd1;
    end
    if (issue && !flush && (stat_issued_q != '1)) begin
      stat_issued_d = stat_issued_q + 32'd1;
    end
  end

  // Statistics registers, cleared only by reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_full_cycles_q <= '0;
      stat_issued_q      <= '0;
    end else begin
      stat_full_cycles_q <= stat_full_cycles_d;
      stat_issued_q      <= stat_issued_d;
    end
  end

  assign stat_full_cycles = stat_full_cycles_q;
  assign stat_issued      = stat_issued_q;
`endif

endmodule

// File: tb/tb_issue_queue.sv
// tb/tb_issue_queue.sv - directed self-checking bench for issue_queue
module tb_issue_queue;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic [3:0] count;
`ifdef ISSUE_QUEUE_STATS_EN
  logic [31:0] stat_full_cycles;
  logic [31:0] stat_issued;
`endif

  int n_cmp;
  int n_err;

  issue_queue_if #(.PHY_BITS(6), .TAG_BITS(4), .PAYLOAD_W(48)) bus ();

  issue_queue #(.DEPTH(8), .PHY_BITS(6), .TAG_BITS(4), .PAYLOAD_W(48)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .flush            (flush),
    .q                (bus.slave),
    .count            (count)
`ifdef ISSUE_QUEUE_STATS_EN
    ,
    .stat_full_cycles (stat_full_cycles),
    .stat_issued      (stat_issued)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_in(input logic v, input logic [5:0] rs, input logic rsr,
                          input logic [5:0] rt, input logic rtr, input logic [5:0] rw,
                          input logic [3:0] tag, input logic [47:0] pl);
    bus.in_valid    = v;
    bus.in_rs_phy   = rs;
    bus.in_rs_ready = rsr;
    bus.in_rt_phy   = rt;
    bus.in_rt_ready = rtr;
    bus.in_rw_phy   = rw;
    bus.in_rob_tag  = tag;
    bus.in_payload  = pl;
  endtask

  task automatic idle_in();
    drive_in(1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 4'd0, 48'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    flush = 1'b0;
    idle_in();
    bus.wb_valid  = 1'b0;
    bus.wb_phy    = 6'd0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;

    // Reset state
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_rw", 64'(bus.out_rw_phy), 64'd0);
    chk("rst_out_tag", 64'(bus.out_rob_tag), 64'd0);
    chk("rst_out_payload", 64'(bus.out_payload), 64'd0);

    // Single ready instruction issues the cycle after enqueue
    bus.out_ready = 1'b1;
    drive_in(1'b1, 6'd5, 1'b1, 6'd6, 1'b1, 6'd40, 4'd3, 48'hABC123);
    tick();
    idle_in();
    chk("t1_out_valid", 64'(bus.out_valid), 64'd1);
    chk("t1_rs", 64'(bus.out_rs_phy), 64'd5);
    chk("t1_rt", 64'(bus.out_rt_phy), 64'd6);
    chk("t1_rw", 64'(bus.out_rw_phy), 64'd40);
    chk("t1_tag", 64'(bus.out_rob_tag), 64'd3);
    chk("t1_payload", 64'(bus.out_payload), 64'hABC123);
    chk("t1_count", 64'(count), 64'd1);
    tick();
    chk("t1_count_after", 64'(count), 64'd0);
    chk("t1_valid_after", 64'(bus.out_valid), 64'd0);

    // Younger ready entry bypasses an older waiting one; wakeup releases the older
    bus.out_ready = 1'b0;
    drive_in(1'b1, 6'd33, 1'b0, 6'd7, 1'b1, 6'd41, 4'd4, 48'd0);
    tick();
    drive_in(1'b1, 6'd8, 1'b1, 6'd9, 1'b1, 6'd42, 4'd5, 48'd0);
    tick();
    idle_in();
    chk("t2_count", 64'(count), 64'd2);
    chk("t2_first_tag", 64'(bus.out_rob_tag), 64'd5);
    bus.out_ready = 1'b1;
    tick();
    chk("t2_count_b", 64'(count), 64'd1);
    chk("t2_a_blocked", 64'(bus.out_valid), 64'd0);
    bus.wb_valid = 1'b1;
    bus.wb_phy   = 6'd33;
    tick();
    bus.wb_valid = 1'b0;
    chk("t2_a_woken", 64'(bus.out_valid), 64'd1);
    chk("t2_a_tag", 64'(bus.out_rob_tag), 64'd4);
    tick();
    chk("t2_empty", 64'(count), 64'd0);

    // Same-cycle wakeup on enqueue is captured; phy 0 counts as ready
    bus.out_ready = 1'b0;
    drive_in(1'b1, 6'd34, 1'b0, 6'd10, 1'b1, 6'd43, 4'd6, 48'd0);
    bus.wb_valid = 1'b1;
    bus.wb_phy   = 6'd34;
    tick();
    bus.wb_valid = 1'b0;
    drive_in(1'b1, 6'd0, 1'b0, 6'd11, 1'b1, 6'd44, 4'd7, 48'd0);
    chk("t3_issuable", 64'(bus.out_valid), 64'd1);
    chk("t3_tag", 64'(bus.out_rob_tag), 64'd6);
    bus.out_ready = 1'b1;
    tick();
    idle_in();
    chk("t3_zero_reg_ready", 64'(bus.out_valid), 64'd1);
    chk("t3_zero_tag", 64'(bus.out_rob_tag), 64'd7);
    tick();
    chk("t3_empty", 64'(count), 64'd0);

    // Collapse from the middle with a wakeup and an append in the same cycle
    bus.out_ready = 1'b0;
    drive_in(1'b1, 6'd20, 1'b0, 6'd2, 1'b1, 6'd45, 4'd1, 48'd0);
    tick();
    drive_in(1'b1, 6'd3, 1'b1, 6'd4, 1'b1, 6'd46, 4'd2, 48'd0);
    tick();
    drive_in(1'b1, 6'd21, 1'b0, 6'd2, 1'b1, 6'd47, 4'd3, 48'd0);
    tick();
    drive_in(1'b1, 6'd3, 1'b1, 6'd4, 1'b1, 6'd48, 4'd9, 48'd0);
    bus.wb_valid  = 1'b1;
    bus.wb_phy    = 6'd21;
    bus.out_ready = 1'b1;
    chk("t4_sel_b", 64'(bus.out_rob_tag), 64'd2);
    tick();
    idle_in();
    bus.wb_valid = 1'b0;
    chk("t4_count3", 64'(count), 64'd3);
    chk("t4_shifted_woken", 64'(bus.out_rob_tag), 64'd3);
    tick();
    chk("t4_append_tag", 64'(bus.out_rob_tag), 64'd9);
    tick();
    chk("t4_count1", 64'(count), 64'd1);
    chk("t4_a_blocked", 64'(bus.out_valid), 64'd0);
    bus.wb_valid = 1'b1;
    bus.wb_phy   = 6'd20;
    tick();
    bus.wb_valid = 1'b0;
    chk("t4_a_tag", 64'(bus.out_rob_tag), 64'd1);
    tick();
    chk("t4_empty", 64'(count), 64'd0);

    // Fill to DEPTH, then enqueue+issue while full: only the issue happens
    bus.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive_in(1'b1, 6'd1, 1'b1, 6'd2, 1'b1, 6'd50, 4'(i), 48'(i));
      tick();
    end
    chk("t5_count_full", 64'(count), 64'd8);
    chk("t5_in_ready_full", 64'(bus.in_ready), 64'd0);
    chk("t5_head_tag", 64'(bus.out_rob_tag), 64'd0);
    drive_in(1'b1, 6'd1, 1'b1, 6'd2, 1'b1, 6'd50, 4'd15, 48'd15);
    bus.out_ready = 1'b1;
    tick();
    idle_in();
    chk("t5_count7", 64'(count), 64'd7);
    chk("t5_in_ready7", 64'(bus.in_ready), 64'd1);
    for (int k = 1; k < 8; k++) begin
      chk($sformatf("t5_order_%0d", k), 64'(bus.out_rob_tag), 64'(k));
      tick();
    end
    chk("t5_drained", 64'(count), 64'd0);
    chk("t5_no_extra", 64'(bus.out_valid), 64'd0);

    // Flush with simultaneous enqueue, wakeup and issue
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_in(1'b1, 6'd1, 1'b1, 6'd2, 1'b1, 6'd51, 4'(i), 48'd0);
      tick();
    end
    chk("t6_count5", 64'(count), 64'd5);
    drive_in(1'b1, 6'd1, 1'b1, 6'd2, 1'b1, 6'd52, 4'd12, 48'd0);
    bus.wb_valid  = 1'b1;
    bus.wb_phy    = 6'd30;
    bus.out_ready = 1'b1;
    flush         = 1'b1;
    chk("t6_preflush_valid", 64'(bus.out_valid), 64'd1);
    tick();
    flush        = 1'b0;
    bus.wb_valid = 1'b0;
    idle_in();
    chk("t6_count0", 64'(count), 64'd0);
    chk("t6_out_valid0", 64'(bus.out_valid), 64'd0);
    chk("t6_in_ready", 64'(bus.in_ready), 64'd1);
    tick();
    chk("t6_enq_absent", 64'(count), 64'd0);

    // Reset in the middle of operation drops entries
    bus.out_ready = 1'b0;
    drive_in(1'b1, 6'd1, 1'b1, 6'd2, 1'b1, 6'd53, 4'd1, 48'd0);
    tick();
    tick();
    chk("t7_count2", 64'(count), 64'd2);
    rst_n = 1'b0;
    flush = 1'b1;
    tick();
    rst_n = 1'b1;
    flush = 1'b0;
    idle_in();
    chk("t7_count0", 64'(count), 64'd0);
    chk("t7_out_valid0", 64'(bus.out_valid), 64'd0);

    // Full for 4 cycles with in_valid, then 3 issues, then flush
    bus.out_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      drive_in(1'b1, 6'd1, 1'b1, 6'd2, 1'b1, 6'd54, 4'(i), 48'd0);
      tick();
    end
    idle_in();
    chk("t8_count8", 64'(count), 64'd8);
    bus.out_ready = 1'b1;
    tick();
    tick();
    tick();
    bus.out_ready = 1'b0;
    chk("t8_count5", 64'(count), 64'd5);
`ifdef ISSUE_QUEUE_STATS_EN
    chk("t8_stat_full", 64'(stat_full_cycles), 64'd4);
    chk("t8_stat_issued", 64'(stat_issued), 64'd3);
`endif
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t8_count_flush", 64'(count), 64'd0);
`ifdef ISSUE_QUEUE_STATS_EN
    chk("t8_stat_full_kept", 64'(stat_full_cycles), 64'd4);
    chk("t8_stat_issued_kept", 64'(stat_issued), 64'd3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
